// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch (issue) stage: register indices,
// the issued-entry bundle and the output-entry state encoding.
package operand_fetch_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 1 << REG_IDX_W;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef struct packed {
        logic [DATA_W-1:0]    rs1_data;
        logic [DATA_W-1:0]    rs2_data;
        reg_idx_t             rd;
        logic                 rd_we;
        logic [PAYLOAD_W-1:0] tag;
    } issue_entry_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    function automatic logic is_live(input reg_idx_t idx);
        return idx != REG_ZERO;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Valid/ready bundles on both sides of the issue stage:
// issue_if from decode, exec_if towards execute.
interface issue_if #(
    parameter int TAG_W = 32
);
    import operand_fetch_pkg::*;

    logic             in_valid;
    logic             in_ready;
    reg_idx_t         in_rs1;
    reg_idx_t         in_rs2;
    reg_idx_t         in_rd;
    logic             in_rd_we;
    logic [TAG_W-1:0] in_tag;

    modport master (
        output in_valid, in_rs1, in_rs2,
        output in_rd, in_rd_we, in_tag,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2,
        input  in_rd, in_rd_we, in_tag,
        output in_ready
    );
endinterface

interface exec_if #(
    parameter int N     = 32,
    parameter int TAG_W = 32
);
    import operand_fetch_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_rs1_data;
    logic [N-1:0]     out_rs2_data;
    reg_idx_t         out_rd;
    logic             out_rd_we;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output out_valid, out_rs1_data, out_rs2_data,
        output out_rd, out_rd_we, out_tag,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_rs1_data, out_rs2_data,
        input  out_rd, out_rd_we, out_tag,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch_hazard_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue,
// cleared by writeback or by flushing the held entry. x0 is never busy.
module hazard_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  logic     fl_en,
    input  reg_idx_t fl_idx,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  reg_idx_t rd,
    output logic     busy_rs1,
    output logic     busy_rs2,
    output logic     busy_rd
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // Set is applied last so a same-index issue outlives a writeback.
    always_comb begin
        busy_next = busy;
        if (clr_en && is_live(clr_idx)) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (fl_en && is_live(fl_idx)) begin
            busy_next[fl_idx] = 1'b0;
        end
        if (set_en && is_live(set_idx)) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_rs1 = busy[rs1];
    assign busy_rs2 = busy[rs2];
    assign busy_rd  = busy[rd];

    // A writeback racing an issue to the same register is the set-wins case.
    a_wb_to_busy: assert property (
        @(posedge clk) disable iff (reset)
        (clr_en && is_live(clr_idx)
         && !(set_en && set_idx == clr_idx))
        |-> busy[clr_idx]
    );

endmodule

// File: rtl/operand_fetch_stage.sv
// Issue stage: RF read, scoreboard hazard hold, one-entry output register.
// Define WB_BYPASS_EN to forward the writeback value into a waiting read.
module operand_fetch_stage
    import operand_fetch_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    issue_if.slave           dec,
    output reg_idx_t         rf_rs1,
    output reg_idx_t         rf_rs2,
    input  logic [N-1:0]     rf_rdata1,
    input  logic [N-1:0]     rf_rdata2,
    input  logic             wb_valid,
    input  reg_idx_t         wb_rd,
    input  logic [N-1:0]     wb_data,
    input  logic             flush,
    exec_if.master           ex,
    output logic [CNT_W-1:0] stall_cnt
);

    if (N != DATA_W || TAG_W != PAYLOAD_W) begin : g_width_check
        $error("issue_entry_t is sized by operand_fetch_pkg");
    end

    out_state_t   state;
    out_state_t   state_next;
    issue_entry_t entry;

    logic         byp1;
    logic         byp2;
    logic         busy_rs1;
    logic         busy_rs2;
    logic         busy_rd;
    logic         hazard;
    logic         out_valid;
    logic         in_ready;
    logic         accept;
    logic         flush_clr;
    logic [N-1:0] op1;
    logic [N-1:0] op2;

    assign rf_rs1 = dec.in_rs1;
    assign rf_rs2 = dec.in_rs2;

`ifdef WB_BYPASS_EN
    assign byp1 = wb_valid && wb_rd == dec.in_rs1
                  && is_live(dec.in_rs1);
    assign byp2 = wb_valid && wb_rd == dec.in_rs2
                  && is_live(dec.in_rs2);
`else
    logic unused_wb_data;

    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign unused_wb_data = ^wb_data;
`endif

    always_comb begin
        op1 = rf_rdata1;
        op2 = rf_rdata2;
        if (!is_live(dec.in_rs1)) begin
            op1 = '0;
        end else if (byp1) begin
            op1 = wb_data;
        end
        if (!is_live(dec.in_rs2)) begin
            op2 = '0;
        end else if (byp2) begin
            op2 = wb_data;
        end
    end

    hazard_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (accept && dec.in_rd_we),
        .set_idx  (dec.in_rd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .fl_en    (flush_clr),
        .fl_idx   (entry.rd),
        .rs1      (dec.in_rs1),
        .rs2      (dec.in_rs2),
        .rd       (dec.in_rd),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd)
    );

    assign hazard = dec.in_valid && (
        (is_live(dec.in_rs1) && busy_rs1 && !byp1) ||
        (is_live(dec.in_rs2) && busy_rs2 && !byp2) ||
        (dec.in_rd_we && is_live(dec.in_rd) && busy_rd));

    assign out_valid = (state == ST_FULL);
    assign in_ready  = !flush && !hazard
                       && (!out_valid || ex.out_ready);
    assign accept    = dec.in_valid && in_ready;

    // The dropped entry never writes back, so release its destination.
    assign flush_clr = flush && out_valid && entry.rd_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    state_next = ST_EMPTY;
                end else if (ex.out_ready && !accept) begin
                    state_next = ST_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry <= '0;
        end else if (accept) begin
            entry <= '{
                rs1_data: op1,
                rs2_data: op2,
                rd:       dec.in_rd,
                rd_we:    dec.in_rd_we,
                tag:      dec.in_tag
            };
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (dec.in_valid && !in_ready
                     && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign dec.in_ready    = in_ready;
    assign ex.out_valid    = out_valid;
    assign ex.out_rs1_data = entry.rs1_data;
    assign ex.out_rs2_data = entry.rs2_data;
    assign ex.out_rd       = entry.rd;
    assign ex.out_rd_we    = entry.rd_we;
    assign ex.out_tag      = entry.tag;

endmodule
